// File: rtl/dram_writer.sv
// AXI3 write master: streams 64-bit beats to DRAM as fixed 16-beat, 128-byte INCR bursts.
// Zero-latency data passthrough; upstream is stalled directly by WREADY, config by CONFIG_READY.
module dram_writer (
  input  logic        ACLK,
  input  logic        ARESETN,
  output logic [31:0] M_AXI_AWADDR,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [3:0]  M_AXI_AWLEN,
  output logic [1:0]  M_AXI_AWSIZE,
  output logic [1:0]  M_AXI_AWBURST,
  output logic [63:0] M_AXI_WDATA,
  output logic [7:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  output logic        M_AXI_WLAST,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        CONFIG_VALID,
  output logic        CONFIG_READY,
  input  logic [31:0] CONFIG_START_ADDR,
  input  logic [31:0] CONFIG_NBYTES,
  input  logic        DATA_VALID,
  output logic        DATA_READY,
  input  logic [63:0] DATA,
  output logic        WRITE_ERROR
);

  localparam logic [0:0] A_IDLE  = 1'b0;
  localparam logic [0:0] A_AWAIT = 1'b1;
  localparam logic [0:0] D_IDLE  = 1'b0;
  localparam logic [0:0] D_WRITE = 1'b1;

  logic [0:0]  a_state;
  logic [0:0]  d_state;
  logic [31:0] awaddr;
  logic [24:0] a_count;
  logic [28:0] beat_total;
  logic [3:0]  beat_idx;
  logic [25:0] b_count;
  logic        write_error;

  logic [24:0] n_bursts;
  logic        accept;
  logic        start;
  logic        aw_hs;
  logic        w_hs;
  logic        b_hs;
  logic        unused_nbytes_lsbs;

  // Low 7 bits of the length are dropped: transfers are whole bursts only.
  assign n_bursts           = CONFIG_NBYTES[31:7];
  assign unused_nbytes_lsbs = ^CONFIG_NBYTES[6:0];

  assign CONFIG_READY = (a_state == A_IDLE) && (d_state == D_IDLE) && (b_count == 26'd0);
  assign accept       = CONFIG_VALID && CONFIG_READY;
  assign start        = accept && (n_bursts != 25'd0);

  assign M_AXI_AWADDR  = awaddr;
  assign M_AXI_AWVALID = (a_state == A_AWAIT);
  assign M_AXI_AWLEN   = 4'b1111;
  assign M_AXI_AWSIZE  = 2'b11;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_WDATA   = DATA;
  assign M_AXI_WSTRB   = 8'hFF;
  assign M_AXI_WVALID  = (d_state == D_WRITE) && DATA_VALID;
  assign DATA_READY    = (d_state == D_WRITE) && M_AXI_WREADY;
  assign M_AXI_WLAST   = (beat_idx == 4'd15);
  assign M_AXI_BREADY  = (b_count != 26'd0);
  assign WRITE_ERROR   = write_error;

  assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID && M_AXI_WREADY;
  assign b_hs  = M_AXI_BVALID && M_AXI_BREADY;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      a_state <= A_IDLE;
      awaddr  <= 32'd0;
      a_count <= 25'd0;
    end else begin
      case (a_state)
        A_IDLE: begin
          if (start) begin
            awaddr  <= CONFIG_START_ADDR;
            a_count <= n_bursts;
            a_state <= A_AWAIT;
          end
        end
        default: begin
          if (aw_hs) begin
            awaddr  <= awaddr + 32'd128;
            a_count <= a_count - 25'd1;
            if (a_count == 25'd1) a_state <= A_IDLE;
          end
        end
      endcase
    end
  end

  // W beats run independently of AW; the interconnect may see data before address.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      d_state    <= D_IDLE;
      beat_total <= 29'd0;
      beat_idx   <= 4'd0;
    end else begin
      case (d_state)
        D_IDLE: begin
          if (start) begin
            beat_total <= {n_bursts, 4'b0000};
            beat_idx   <= 4'd0;
            d_state    <= D_WRITE;
          end
        end
        default: begin
          if (w_hs) begin
            beat_idx   <= beat_idx + 4'd1;
            beat_total <= beat_total - 29'd1;
            if (beat_total == 29'd1) d_state <= D_IDLE;
          end
        end
      endcase
    end
  end

  // BREADY is gated by the count, so stray responses at zero never underflow it.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      b_count     <= 26'd0;
      write_error <= 1'b0;
    end else if (accept) begin
      b_count     <= {1'b0, n_bursts};
      write_error <= 1'b0;
    end else if (b_hs) begin
      b_count <= b_count - 26'd1;
      if (M_AXI_BRESP != 2'b00) write_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dram_writer.sv
// Directed bench for dram_writer: a behavioural AXI slave plus handshake recorder, checked step by step.
module tb_dram_writer;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [31:0] M_AXI_AWADDR;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY;
  logic [3:0]  M_AXI_AWLEN;
  logic [1:0]  M_AXI_AWSIZE;
  logic [1:0]  M_AXI_AWBURST;
  logic [63:0] M_AXI_WDATA;
  logic [7:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID;
  logic        M_AXI_WREADY;
  logic        M_AXI_WLAST;
  logic        M_AXI_BVALID;
  logic        M_AXI_BREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        CONFIG_VALID;
  logic        CONFIG_READY;
  logic [31:0] CONFIG_START_ADDR;
  logic [31:0] CONFIG_NBYTES;
  logic        DATA_VALID;
  logic        DATA_READY;
  logic [63:0] DATA;
  logic        WRITE_ERROR;

  dram_writer dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_AWLEN(M_AXI_AWLEN), .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
    .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_WLAST(M_AXI_WLAST),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_BRESP(M_AXI_BRESP),
    .CONFIG_VALID(CONFIG_VALID), .CONFIG_READY(CONFIG_READY),
    .CONFIG_START_ADDR(CONFIG_START_ADDR), .CONFIG_NBYTES(CONFIG_NBYTES),
    .DATA_VALID(DATA_VALID), .DATA_READY(DATA_READY), .DATA(DATA),
    .WRITE_ERROR(WRITE_ERROR)
  );

  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad = 0;

  logic [31:0] aw_q[$];
  logic [63:0] w_q[$];
  bit          wl_q[$];
  int          b_cnt, nlast, aw_vld_seen, w_vld_seen, first_aw_wcnt;
  bit          timed_out;
  logic        err_after_acc;
  bit          aw_stall_prev = 1'b0;
  logic [31:0] aw_addr_prev = 32'd0;

  // Recorder: sampled mid-cycle, the values here are exactly those seen at the next rising edge.
  always @(negedge ACLK) begin
    if (M_AXI_AWVALID) aw_vld_seen++;
    if (M_AXI_WVALID) w_vld_seen++;
    if (aw_stall_prev && ARESETN) begin
      total++;
      assert (M_AXI_AWVALID === 1'b1 && M_AXI_AWADDR === aw_addr_prev)
      else begin
        bad++;
        $error("FAIL awaddr_hold observed vld=%b addr=%h expected vld=1 addr=%h",
               M_AXI_AWVALID, M_AXI_AWADDR, aw_addr_prev);
      end
    end
    aw_stall_prev = M_AXI_AWVALID && !M_AXI_AWREADY;
    aw_addr_prev  = M_AXI_AWADDR;
    if (M_AXI_AWVALID && M_AXI_AWREADY) begin
      if (first_aw_wcnt < 0) first_aw_wcnt = w_q.size();
      aw_q.push_back(M_AXI_AWADDR);
    end
    if (M_AXI_WVALID && M_AXI_WREADY) begin
      w_q.push_back(M_AXI_WDATA);
      wl_q.push_back(M_AXI_WLAST);
      if (M_AXI_WLAST) nlast++;
    end
    if (M_AXI_BVALID && M_AXI_BREADY) b_cnt++;
  end

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    CONFIG_VALID  = 1'b0;
    DATA_VALID    = 1'b0;
    DATA          = 64'd0;
    M_AXI_AWREADY = 1'b0;
    M_AXI_WREADY  = 1'b0;
    M_AXI_BVALID  = 1'b0;
    M_AXI_BRESP   = 2'b00;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_awaddr", {32'd0, M_AXI_AWADDR}, 64'd0);
    chk("rst_awvalid", {63'd0, M_AXI_AWVALID}, 64'd0);
    chk("rst_wvalid", {63'd0, M_AXI_WVALID}, 64'd0);
    chk("rst_wlast", {63'd0, M_AXI_WLAST}, 64'd0);
    chk("rst_bready", {63'd0, M_AXI_BREADY}, 64'd0);
    chk("rst_data_ready", {63'd0, DATA_READY}, 64'd0);
    chk("rst_config_ready", {63'd0, CONFIG_READY}, 64'd1);
    chk("rst_write_error", {63'd0, WRITE_ERROR}, 64'd0);
  endtask

  // One config plus a slave that answers B only for bursts whose AW and last W are both done.
  task automatic run_xfer(input logic [31:0] start, input logic [31:0] nbytes, input logic [63:0] base,
                          input bit stall, input int aw_delay, input int bad_b, input int rst_at);
    int it;
    int avail;
    aw_q.delete(); w_q.delete(); wl_q.delete();
    b_cnt = 0; nlast = 0; aw_vld_seen = 0; w_vld_seen = 0; first_aw_wcnt = -1; timed_out = 0;
    idle_inputs();
    CONFIG_START_ADDR = start;
    CONFIG_NBYTES     = nbytes;
    CONFIG_VALID      = 1'b1;
    step();
    CONFIG_VALID  = 1'b0;
    err_after_acc = WRITE_ERROR;
    it = 0;
    while (!CONFIG_READY) begin
      if (it >= 3000) begin
        timed_out = 1;
        break;
      end
      if (rst_at > 0 && w_q.size() == rst_at) begin
        ARESETN = 1'b0;
        step();
        ARESETN = 1'b1;
        break;
      end
      DATA_VALID    = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      DATA          = base + 64'(w_q.size());
      M_AXI_AWREADY = (it < aw_delay) ? 1'b0 : (stall ? 1'($urandom_range(0, 1)) : 1'b1);
      M_AXI_WREADY  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      avail = ((aw_q.size() < nlast) ? aw_q.size() : nlast) - b_cnt;
      M_AXI_BVALID  = (avail > 0) && (stall ? 1'($urandom_range(0, 1)) : 1'b1);
      M_AXI_BRESP   = (b_cnt == bad_b) ? 2'b10 : 2'b00;
      step();
      it++;
    end
    idle_inputs();
  endtask

  task automatic chk_xfer(input logic [31:0] start, input int n, input logic [63:0] base);
    chk("timeout", {63'd0, timed_out}, 64'd0);
    chk("aw_count", 64'(aw_q.size()), 64'(n));
    for (int i = 0; i < aw_q.size() && i < n; i++)
      chk("awaddr", {32'd0, aw_q[i]}, {32'd0, start + 32'(128 * i)});
    chk("w_count", 64'(w_q.size()), 64'(16 * n));
    for (int i = 0; i < w_q.size() && i < 16 * n; i++) begin
      chk("wdata", w_q[i], base + 64'(i));
      chk("wlast", {63'd0, wl_q[i]}, {63'd0, (i % 16) == 15});
    end
    chk("b_count_at_ready", 64'(b_cnt), 64'(n));
    chk("config_ready_end", {63'd0, CONFIG_READY}, 64'd1);
  endtask

  initial begin
    ARESETN = 1'b0;
    CONFIG_START_ADDR = 32'd0;
    CONFIG_NBYTES = 32'd0;
    idle_inputs();
    repeat (3) step();
    chk_reset_outputs();
    chk("awlen", {60'd0, M_AXI_AWLEN}, 64'hF);
    chk("awsize_burst", {60'd0, M_AXI_AWSIZE, M_AXI_AWBURST}, 64'hD);
    chk("wstrb", {56'd0, M_AXI_WSTRB}, 64'hFF);
    ARESETN = 1'b1;
    step();

    // Two bursts, no stalls.
    run_xfer(32'h1000_0000, 32'd256, 64'd0, 1'b0, 0, -1, 0);
    chk_xfer(32'h1000_0000, 2, 64'd0);

    // Sub-burst length: no-op, and a stray response while idle is not accepted.
    run_xfer(32'h2000_0000, 32'h7F, 64'd0, 1'b0, 0, -1, 0);
    chk("noop_ready", {63'd0, CONFIG_READY}, 64'd1);
    DATA_VALID = 1'b1; M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1;
    repeat (5) step();
    chk("noop_awvalid_seen", 64'(aw_vld_seen), 64'd0);
    chk("noop_wvalid_seen", 64'(w_vld_seen), 64'd0);
    chk("noop_data_ready", {63'd0, DATA_READY}, 64'd0);
    idle_inputs();
    M_AXI_BVALID = 1'b1; M_AXI_BRESP = 2'b10;
    step();
    chk("stray_b_bready", {63'd0, M_AXI_BREADY}, 64'd0);
    step();
    chk("stray_b_error", {63'd0, WRITE_ERROR}, 64'd0);
    chk("stray_b_ready", {63'd0, CONFIG_READY}, 64'd1);
    idle_inputs();

    // Random stalls on every channel.
    run_xfer(32'h3000_0080, 32'd128, 64'h100, 1'b1, 0, -1, 0);
    chk_xfer(32'h3000_0080, 1, 64'h100);

    // All data ahead of the address.
    run_xfer(32'h4000_0000, 32'd128, 64'h200, 1'b0, 40, -1, 0);
    chk_xfer(32'h4000_0000, 1, 64'h200);
    chk("w_before_aw", 64'(first_aw_wcnt), 64'd16);

    // Error response on the second burst; also wraps AWADDR past 2^32.
    run_xfer(32'hFFFF_FF80, 32'd384, 64'h300, 1'b0, 0, 1, 0);
    chk_xfer(32'hFFFF_FF80, 3, 64'h300);
    chk("error_set", {63'd0, WRITE_ERROR}, 64'd1);
    repeat (3) step();
    chk("error_sticky", {63'd0, WRITE_ERROR}, 64'd1);

    // Reset mid-transfer; the config accept of this transfer must also clear the error.
    run_xfer(32'h5000_0000, 32'd256, 64'h400, 1'b0, 0, -1, 5);
    chk("error_clear_on_accept", {63'd0, err_after_acc}, 64'd0);
    chk_reset_outputs();

    run_xfer(32'h6000_0000, 32'd128, 64'h500, 1'b0, 0, -1, 0);
    chk_xfer(32'h6000_0000, 1, 64'h500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
